// File: rtl/arbiter_pkg.sv
// arbiter_pkg -- shared definitions for shared_op_arbiter and rr_pick.
//   * FSM state encoding (IDLE / EXEC / RESP)
//   * operator-name constants used to select the arithmetic at elaboration
//   * clog2(): index width helper that never returns 0, so a counter or id
//     port always has at least one bit
package arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    RESP = ST_RESP
  } state_e;

  localparam OP_ADD = "add";
  localparam OP_SUB = "sub";
  localparam OP_MUL = "mul";

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- combinational round-robin selector.
// Ports:
//   req   in  per-client request levels
//   last  in  index of the client served most recently
//   found out at least one request is present
//   idx   out first requester at or after last+1, wrapping at num_clients
// The request vector is rotated so that client last+1 lands in bit 0, the
// lowest set bit is priority-encoded, and the offset is rotated back.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int unsigned num_clients = 4,
  parameter int unsigned id_w        = clog2(num_clients)
) (
  input  logic [num_clients-1:0] req,
  input  logic [id_w-1:0]        last,
  output logic                   found,
  output logic [id_w-1:0]        idx
);

  logic [2*num_clients-1:0] req_dbl;
  logic [num_clients-1:0]   rot;
  int unsigned              start;
  int unsigned              off;
  int unsigned              sum;

  assign req_dbl = {req, req};

  // NOTE: every variable written here gets a value before any branch, so no
  // path leaves one holding its old value and no latch is inferred.
  always_comb begin
    found = 1'b0;
    off   = 0;
    start = 32'(last) + 32'd1;
    if (start >= num_clients) start = 0;

    rot = num_clients'(req_dbl >> start);

    for (int k = num_clients - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end

    sum = start + off;
    if (sum >= num_clients) sum = sum - num_clients;
    idx = id_w'(sum);
  end

endmodule

// File: rtl/shared_op_arbiter.sv
// shared_op_arbiter -- one arithmetic operator time-shared round-robin
// between num_clients dataflow nodes using a level-req / one-cycle-ack
// handshake. One operation is in flight at a time; operator latency is
// modelled by a countdown.
// Ports:
//   clk       in  rising-edge clock
//   rst       in  asynchronous active-low reset
//   req       in  per-client request level (sampled only in IDLE)
//   din       in  client i: a at [2*dw*i +: dw], b at the next dw bits
//   ack       out one-cycle pulse to the client whose result is on dout
//   dout      out shared result register
//   grant_id  out client currently or last served
//   busy      out high while in EXEC or RESP
//   count     out completed operations, wraps modulo 2^32
module shared_op_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned data_width  = 32,
  parameter int unsigned num_clients = 4,
  parameter              op          = "mul",
  parameter int unsigned latency     = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [num_clients-1:0]              req,
  input  logic [2*data_width*num_clients-1:0] din,
  output logic [num_clients-1:0]              ack,
  output logic [data_width-1:0]               dout,
  output logic [clog2(num_clients)-1:0]       grant_id,
  output logic                                busy,
  output logic [31:0]                         count
);

  localparam int unsigned ID_W  = clog2(num_clients);
  localparam int unsigned CNT_W = clog2(latency);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [data_width-1:0]  a_q, a_d, b_q, b_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [num_clients-1:0] ack_q, ack_d;
  logic [data_width-1:0]  dout_q, dout_d;
  logic [31:0]            count_q, count_d;
  logic                   busy_q, busy_d;

  logic                   pick_found;
  logic [ID_W-1:0]        pick_idx;
  logic [data_width-1:0]  a_sel, b_sel;
  logic [data_width-1:0]  result;

  rr_pick #(
    .num_clients (num_clients),
    .id_w        (ID_W)
  ) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Operand mux for the picked client.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < num_clients; i++) begin
      if (pick_idx == ID_W'(i)) begin
        a_sel = din[2*data_width*i +: data_width];
        b_sel = din[2*data_width*i + data_width +: data_width];
      end
    end
  end

  // Operator chosen at elaboration; results truncate to data_width.
  if (op == OP_ADD) begin : g_add
    assign result = a_q + b_q;
  end else if (op == OP_SUB) begin : g_sub
    assign result = a_q - b_q;
  end else begin : g_mul
    assign result = a_q * b_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack_d   = '0;
    dout_d  = dout_q;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          a_d     = a_sel;
          b_d     = b_sel;
          grant_d = pick_idx;
          cnt_d   = CNT_W'(latency - 1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          dout_d  = result;
          ack_d   = num_clients'(1) << grant_q;
          count_d = count_q + 32'd1;
          last_d  = grant_q;
          state_d = RESP;
        end
      end
      // RESP is a gap cycle so a client that drops req on seeing ack is
      // never resampled with its stale request.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  // Operand registers are reset too: reset must discard any in-flight work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      grant_q <= '0;
      last_q  <= ID_W'(num_clients - 1);
      ack_q   <= '0;
      dout_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign dout     = dout_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign count    = count_q;

endmodule

// File: tb/tb_shared_op_arbiter.sv
// Directed bench for shared_op_arbiter: a 4-client 32-bit mul instance
// (latency 2) plus 2-client 8-bit sub (latency 2) and add (latency 1)
// instances for truncation and minimum-latency cases.
module tb_shared_op_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // mul instance
  logic [3:0]   req_m, ack_m;
  logic [255:0] din_m;
  logic [31:0]  dout_m, count_m;
  logic [1:0]   gid_m;
  logic         busy_m;

  // sub instance
  logic [1:0]   req_s, ack_s;
  logic [31:0]  din_s, count_s;
  logic [7:0]   dout_s;
  logic [0:0]   gid_s;
  logic         busy_s;

  // add instance
  logic [1:0]   req_a, ack_a;
  logic [31:0]  din_a, count_a;
  logic [7:0]   dout_a;
  logic [0:0]   gid_a;
  logic         busy_a;

  shared_op_arbiter #(
    .data_width (32), .num_clients (4), .op ("mul"), .latency (2)
  ) u_mul (
    .clk (clk), .rst (rst), .req (req_m), .din (din_m), .ack (ack_m),
    .dout (dout_m), .grant_id (gid_m), .busy (busy_m), .count (count_m)
  );

  shared_op_arbiter #(
    .data_width (8), .num_clients (2), .op ("sub"), .latency (2)
  ) u_sub (
    .clk (clk), .rst (rst), .req (req_s), .din (din_s), .ack (ack_s),
    .dout (dout_s), .grant_id (gid_s), .busy (busy_s), .count (count_s)
  );

  shared_op_arbiter #(
    .data_width (8), .num_clients (2), .op ("add"), .latency (1)
  ) u_add (
    .clk (clk), .rst (rst), .req (req_a), .din (din_a), .ack (ack_a),
    .dout (dout_a), .grant_id (gid_a), .busy (busy_a), .count (count_a)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic [31:0] a, input logic [31:0] b);
    din_m[64*i +: 32]      = a;
    din_m[64*i + 32 +: 32] = b;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Ticks until the mul instance raises any ack; waited = edges consumed.
  task automatic wait_ack_m(input int budget, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (ack_m == '0 && waited < budget);
    if (ack_m == '0) check("ack_seen", 64'(ack_m != '0), 1);
  endtask

  int w;

  // random-phase state
  bit   [3:0]  pend, just;
  int          issued, dups, bad, multi, cyc;
  int          acked [4];
  int          reqs  [4];
  int          rate  [4];
  logic [31:0] exp_r [4];
  logic [31:0] ra, rb;

  initial begin
    rst   = 1'b0;
    req_m = '0; din_m = '0;
    req_s = '0; din_s = '0;
    req_a = '0; din_a = '0;

    // ---- reset values
    #3;
    check("rst_ack",   ack_m,   0);
    check("rst_dout",  dout_m,  0);
    check("rst_gid",   gid_m,   0);
    check("rst_busy",  busy_m,  0);
    check("rst_count", count_m, 0);
    check("rst_sub_dout", dout_s, 0);
    tick();
    tick();
    rst = 1'b1;

    // ---- single request, client 1: 6*7
    set_m(1, 32'd6, 32'd7);
    req_m = 4'b0010;
    tick();                                  // grant edge E0
    check("t1_busy_grant", busy_m, 1);
    check("t1_gid", gid_m, 1);
    check("t1_ack_grant", ack_m, 0);
    wait_ack_m(10, w);
    check("t1_latency", w, 2);               // ack at E0+latency
    check("t1_ack", ack_m, 4'b0010);
    check("t1_dout", dout_m, 42);
    check("t1_count", count_m, 1);
    check("t1_busy_resp", busy_m, 1);
    req_m = '0;
    tick();
    check("t1_ack_pulse", ack_m, 0);
    check("t1_busy_idle", busy_m, 0);
    check("t1_dout_hold", dout_m, 42);

    // ---- all four clients requesting: order 0,1,2,3,0 every 4 cycles
    apply_reset();
    for (int i = 0; i < 4; i++) set_m(i, 32'(i + 1), 32'd10);
    req_m = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ack_m(12, w);
      check($sformatf("t2_gap%0d", k), w, (k == 0) ? 3 : 4);
      check($sformatf("t2_ack%0d", k), ack_m, 4'b0001 << (k % 4));
      check($sformatf("t2_dout%0d", k), dout_m, ((k % 4) + 1) * 10);
    end
    req_m = '0;
    check("t2_count", count_m, 5);
    tick();
    tick();

    // ---- sub 8-bit: 3-5 wraps to 254, then 10-4
    din_s = {8'd4, 8'd10, 8'd5, 8'd3};
    req_s = 2'b01;
    tick(); tick(); tick();
    check("t3_sub_ack0", ack_s, 2'b01);
    check("t3_sub_dout0", dout_s, 254);
    req_s = '0;
    tick();
    req_s = 2'b10;
    tick(); tick(); tick();
    check("t3_sub_ack1", ack_s, 2'b10);
    check("t3_sub_dout1", dout_s, 6);
    req_s = '0;
    tick();

    // ---- add 8-bit, latency 1: 255+1 -> 0, 200+100 -> 44
    din_a = {8'd100, 8'd200, 8'd1, 8'd255};
    req_a = 2'b01;
    tick();
    check("t3_add_noack_exec", ack_a, 0);
    tick();
    check("t3_add_ack0", ack_a, 2'b01);
    check("t3_add_dout0", dout_a, 0);
    req_a = '0;
    tick();
    check("t3_add_ack_pulse", ack_a, 0);
    req_a = 2'b10;
    tick(); tick();
    check("t3_add_ack1", ack_a, 2'b10);
    check("t3_add_dout1", dout_a, 44);
    check("t3_add_count", count_a, 2);
    req_a = '0;
    tick();

    // ---- client 2 drops req and changes din after grant
    set_m(2, 32'd5, 32'd9);
    req_m = 4'b0100;
    tick();
    check("t4_gid", gid_m, 2);
    req_m = 4'b1011;
    set_m(2, 32'd100, 32'd100);
    tick();
    check("t4_no_ack_exec", ack_m, 0);
    tick();
    check("t4_ack", ack_m, 4'b0100);
    check("t4_dout", dout_m, 45);
    tick();
    check("t4_ack_resp", ack_m, 0);
    tick();
    check("t4_next_gid", gid_m, 3);          // search resumes after client 2
    req_m = '0;
    wait_ack_m(10, w);
    check("t4_next_ack", ack_m, 4'b1000);
    check("t4_next_dout", dout_m, 40);
    tick();
    tick();

    // ---- reset during EXEC
    set_m(1, 32'd6, 32'd7);
    req_m = 4'b0010;
    tick();                                  // grant
    tick();                                  // countdown reaches 0
    rst = 1'b0;
    #1;
    check("t5_rst_ack",   ack_m,   0);
    check("t5_rst_dout",  dout_m,  0);
    check("t5_rst_gid",   gid_m,   0);
    check("t5_rst_busy",  busy_m,  0);
    check("t5_rst_count", count_m, 0);
    set_m(3, 32'd2, 32'd3);
    req_m = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t5_ack_in_rst%0d", k), ack_m, 0);
    end
    rst = 1'b1;
    tick();
    check("t5_first_gid", gid_m, 1);
    wait_ack_m(10, w);
    check("t5_ack", ack_m, 4'b0010);
    check("t5_dout", dout_m, 42);
    check("t5_count", count_m, 1);
    req_m = 4'b1000;
    wait_ack_m(10, w);
    check("t5_ack3", ack_m, 4'b1000);
    check("t5_dout3", dout_m, 6);
    req_m = '0;
    tick();
    tick();

    // ---- random client models, 5000 operations
    apply_reset();
    rate = '{20, 50, 80, 95};
    pend = '0; just = '0;
    issued = 0; dups = 0; bad = 0; multi = 0; cyc = 0;
    for (int i = 0; i < 4; i++) begin
      acked[i] = 0;
      reqs[i]  = 0;
      exp_r[i] = '0;
    end
    while ((issued < 5000 || pend != '0) && cyc < 60000) begin
      tick();
      cyc++;
      if ($countones(ack_m) > 1) multi++;
      for (int i = 0; i < 4; i++) begin
        just[i] = ack_m[i];
        if (ack_m[i]) begin
          if (!pend[i]) dups++;
          else begin
            if (dout_m !== exp_r[i]) bad++;
            acked[i]++;
          end
          pend[i]  = 1'b0;
          req_m[i] = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && !just[i] && issued < 5000 &&
            $urandom_range(99) < 32'(rate[i])) begin
          ra = $urandom;
          rb = $urandom;
          set_m(i, ra, rb);
          exp_r[i] = ra * rb;
          pend[i]  = 1'b1;
          req_m[i] = 1'b1;
          reqs[i]++;
          issued++;
        end
      end
    end
    check("t6_done", 64'(pend == '0 && issued == 5000), 1);
    check("t6_dups", dups, 0);
    check("t6_dout_bad", bad, 0);
    check("t6_multi_ack", multi, 0);
    for (int i = 0; i < 4; i++)
      check($sformatf("t6_acks_c%0d", i), acked[i], reqs[i]);
    check("t6_count", count_m, 5000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shared_op_arbiter.md
# shared_op_arbiter

Time-multiplexes one arithmetic operator between `num_clients` dataflow nodes using the codebase's level-req / one-cycle-ack handshake. It sits inside an `arf` array in place of duplicated expensive operators (typically `mul`). Clients see it as an ordinary upstream producer: they raise `req`, and they receive an `ack` pulse with the result on `dout`. The arbiter keeps one operation in flight at a time, grants clients round-robin, and models the operator latency with a countdown.

## Interface
- `data_width`, 32, operand and result width.
- `num_clients`, 4, number of requesting nodes; must be ≥2.
- `op`, "mul", one of "add", "sub", "mul".
- `latency`, 2, operator cycles; must be ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  num_clients  per-client request level.
- `din`  in  2*data_width*num_clients  client i operand pair. Bits `[2*data_width*i +: data_width]` = a_i; the next `data_width` bits = b_i.
- `ack`  out  num_clients  one-cycle pulse marking `dout` valid for the granted client.
- `dout`  out  data_width  result register, shared by all clients.
- `grant_id`  out  clog2(num_clients)  client currently or last served.
- `busy`  out  1  high in EXEC and RESP.
- `count`  out  32  completed operations; wraps modulo 2^32.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE**, when any `req[i]` is high:
  - choose the first requester searching from `last+1` upward, wrapping at `num_clients`;
  - latch a_i and b_i into operand registers;
  - `grant_id`←i; `cnt`←latency−1; go to EXEC.
- **IDLE**, when no `req` is high: stay in IDLE.
- **EXEC**:
  - if `cnt`≠0: `cnt`←`cnt`−1;
  - else: `dout`←op(a,b); `ack[grant_id]`←1; `count`←`count`+1; `last`←`grant_id`; go to RESP.
- **RESP**: `ack`←0; go to IDLE.
  - RESP is a mandatory gap cycle. The client clears its `req` on the edge where it sees `ack`, so its stale request is never resampled.
- Arithmetic:
  - add: a+b;
  - sub: a−b;
  - mul: a*b.
  - All results are unsigned and truncated to the low `data_width` bits.
- `req` is sampled only in IDLE. A `req` change or a `din` change during EXEC/RESP does not affect the in-flight operation, and its result is still delivered.
- At most one `ack` bit is high in any cycle, and never two consecutive cycles to the same client.
- Reset values: state IDLE, `ack` 0, `dout` 0, `grant_id` 0, `busy` 0, `count` 0, `cnt` 0, `last` = num_clients−1 (client 0 has first priority).

## Timing
- Let the grant occur at edge E0. Then `ack` is high from edge E0+latency to E0+latency+1, with `dout` stable from E0+latency until the next completion.
- The next grant occurs no earlier than edge E0+latency+2. Sustained throughput is one operation per latency+2 cycles.
- `busy` is registered: high from E0 to E0+latency+2.
- Reset asserted mid-operation:
  - all registers clear immediately (asynchronously) and the in-flight result is discarded;
  - no `ack` is issued for it;
  - after release, arbitration restarts from client 0.
- Simultaneous requests from all clients are served in order 0,1,…,N−1,0,…
- A lone requester is re-granted back-to-back every latency+2 cycles.

## Structure
- Package `arbiter_pkg` holds:
  - the state encoding localparams (IDLE/EXEC/RESP);
  - the op-name constants;
  - a clog2 function.
- Sub-module `rr_pick` is combinational:
  - inputs `req` and `last`;
  - outputs `found` and `idx`;
  - implemented as a rotate, priority-encode, unrotate.
- The top level holds the FSM, countdown, operand registers, operator expression and `count`.

## Test plan
- Reset, then op=mul, latency=2. Client 1 requests with a=6, b=7 → `ack[1]` is a single pulse 2 cycles after the grant edge; `dout`=42; `count`=1; `grant_id`=1.
- All 4 clients hold `req` continuously, with client i operands a=i+1, b=10 → acks arrive in order 0,1,2,3,0 at a spacing of latency+2=4 cycles; `dout` values are 10,20,30,40,10.
- op=sub, data_width=8, a=3, b=5 → `dout`=254. op=add, a=255, b=1 → `dout`=0 (truncation).
- Client 2 drops `req` and changes `din` one cycle after its grant → the ack still goes to client 2 with the originally latched result; no ack goes to anyone else during EXEC.
- `rst` is pulled low during EXEC and released after 3 cycles → no ack for the aborted operation; all outputs read 0 while in reset; the first grant after release goes to the lowest-indexed requester.
- Drive client models with the codebase's async_operator req/ack protocol for 5000 operations at random request rates → per-client ack totals match the requests, no ack is duplicated, and `count`=5000.
